// File: rtl/regfile_pkg.sv
// Shared widths, register-number/data types and fetch FSM states for the
// operand-fetch stage that sits in front of the 8x16 register file.
package regfile_pkg;

    localparam int DATA_W = 16;
    localparam int REG_AW = 3;

    typedef enum logic [1:0] {
        IDLE,
        RD_A,
        RD_B,
        HOLD
    } fetch_state_t;

    typedef logic [REG_AW-1:0] reg_num_t;
    typedef logic [DATA_W-1:0] reg_data_t;

endpackage

// File: rtl/operand_sel.sv
// Chooses the value captured for an operand: register-file read data, or the
// writeback data landing in that same register this cycle (OPERAND_FETCH_BYPASS_EN).
module operand_sel
    import regfile_pkg::*;
(
    input  reg_num_t  rs,
    input  reg_data_t rf_data,
    input  logic      wb_valid,
    input  reg_num_t  wb_rd,
    input  reg_data_t wb_data,
    output reg_data_t sel_data
);

`ifdef OPERAND_FETCH_BYPASS_EN
    // The file commits wb_data on the same edge that captures the operand, so
    // rf_data still shows the old value; forward the new one instead.
    assign sel_data = (wb_valid && (wb_rd == rs)) ? wb_data : rf_data;
`else
    logic unused_bypass;
    assign unused_bypass = ^{rs, wb_valid, wb_rd, wb_data};
    assign sel_data      = rf_data;
`endif

endmodule

// File: rtl/operand_fetch.sv
// Operand-fetch stage: reads rs_a then rs_b through the single register-file read
// port and holds the pair for the ALU. Optional forwarding: OPERAND_FETCH_BYPASS_EN.
module operand_fetch
    import regfile_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [REG_AW-1:0] req_rs_a,
    input  logic [REG_AW-1:0] req_rs_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_a,
    output logic [DATA_W-1:0] out_b,
    input  logic              wb_valid,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic [DATA_W-1:0] wb_data,
    output logic [REG_AW-1:0] rf_readnum,
    input  logic [DATA_W-1:0] rf_data,
    output logic              rf_write,
    output logic [REG_AW-1:0] rf_wnum,
    output logic [DATA_W-1:0] rf_wdata
);

    fetch_state_t state_reg;
    reg_num_t     rs_a_reg;
    reg_num_t     rs_b_reg;
    reg_data_t    a_reg;
    reg_data_t    b_reg;
    logic         req_ready_reg;
    logic         out_valid_reg;
    reg_data_t    sel_data;

    // Writeback never waits on the fetch FSM, not even in reset.
    assign rf_write = wb_valid;
    assign rf_wnum  = wb_rd;
    assign rf_wdata = wb_data;

    always_comb begin
        rf_readnum = '0;
        case (state_reg)
            RD_A:    rf_readnum = rs_a_reg;
            RD_B:    rf_readnum = rs_b_reg;
            default: rf_readnum = '0;
        endcase
    end

    operand_sel u_operand_sel (
        .rs       (rf_readnum),
        .rf_data  (rf_data),
        .wb_valid (wb_valid),
        .wb_rd    (wb_rd),
        .wb_data  (wb_data),
        .sel_data (sel_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            rs_a_reg      <= '0;
            rs_b_reg      <= '0;
            a_reg         <= '0;
            b_reg         <= '0;
            req_ready_reg <= 1'b1;
            out_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (req_valid) begin
                        rs_a_reg      <= req_rs_a;
                        rs_b_reg      <= req_rs_b;
                        req_ready_reg <= 1'b0;
                        state_reg     <= RD_A;
                    end
                end
                RD_A: begin
                    a_reg     <= sel_data;
                    state_reg <= RD_B;
                end
                RD_B: begin
                    b_reg         <= sel_data;
                    out_valid_reg <= 1'b1;
                    state_reg     <= HOLD;
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        req_ready_reg <= 1'b1;
                        state_reg     <= IDLE;
                    end
                end
                default: begin
                    out_valid_reg <= 1'b0;
                    req_ready_reg <= 1'b1;
                    state_reg     <= IDLE;
                end
            endcase
        end
    end

    assign req_ready = req_ready_reg;
    assign out_valid = out_valid_reg;
    assign out_a     = a_reg;
    assign out_b     = b_reg;

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: behavioural 8x16 register file, vector table of fetches,
// scoreboard queue of expected operand pairs, and hand-written reset/bypass/back-to-back cases.
module tb_operand_fetch;
    import regfile_pkg::*;

    logic      clk = 1'b0;
    logic      reset;
    logic      req_valid;
    logic      req_ready;
    reg_num_t  req_rs_a;
    reg_num_t  req_rs_b;
    logic      out_valid;
    logic      out_ready;
    reg_data_t out_a;
    reg_data_t out_b;
    logic      wb_valid;
    reg_num_t  wb_rd;
    reg_data_t wb_data;
    reg_num_t  rf_readnum;
    reg_data_t rf_data;
    logic      rf_write;
    reg_num_t  rf_wnum;
    reg_data_t rf_wdata;

    always #5 clk = ~clk;

    operand_fetch dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_rs_a   (req_rs_a),
        .req_rs_b   (req_rs_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_a      (out_a),
        .out_b      (out_b),
        .wb_valid   (wb_valid),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .rf_readnum (rf_readnum),
        .rf_data    (rf_data),
        .rf_write   (rf_write),
        .rf_wnum    (rf_wnum),
        .rf_wdata   (rf_wdata)
    );

    // Register file: combinational read, write on posedge.
    reg_data_t rf_mem [8];
    initial for (int i = 0; i < 8; i++) rf_mem[i] = '0;
    always @(posedge clk) if (rf_write) rf_mem[rf_wnum] <= rf_wdata;
    assign rf_data = rf_mem[rf_readnum];

    int n_cmp  = 0;
    int n_fail = 0;
    logic [31:0] sb_q [$];
    int wr6_cnt = 0;
    bit wr6_en  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end else begin
            $display("ok   %s: 0x%0h at %0t", name, act, $time);
        end
    endtask

    // Scoreboard: every handshake on the output side pops one expected pair.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                check("unexpected_output", 32'd1, 32'd0);
            end else begin
                logic [31:0] e;
                e = sb_q.pop_front();
                check("pair_a", {16'h0, out_a}, {16'h0, e[31:16]});
                check("pair_b", {16'h0, out_b}, {16'h0, e[15:0]});
            end
        end
    end

    always @(posedge clk) if (wr6_en && rf_write && rf_wnum == 3'd6) wr6_cnt++;

    task automatic wb_write(input reg_num_t r, input reg_data_t d);
        wb_valid = 1'b1; wb_rd = r; wb_data = d;
        @(posedge clk); #1;
        wb_valid = 1'b0;
    endtask

    // Entry and exit: 1 time unit after a posedge with the DUT idle.
    task automatic fetch(input reg_num_t a, input reg_num_t b, input reg_data_t ea,
                         input reg_data_t eb, input int hold, input bit wb_rda,
                         input reg_data_t wbd);
        int cnt;
        bit got;
        req_valid = 1'b1; req_rs_a = a; req_rs_b = b;
        out_ready = (hold == 0);
        @(negedge clk);
        check("req_ready_idle", {31'h0, req_ready}, 32'd1);
        @(posedge clk);
        sb_q.push_back({ea, eb});
        #1;
        req_valid = 1'b0;
        if (wb_rda) begin
            wb_valid = 1'b1; wb_rd = a; wb_data = wbd;
        end
        cnt = 0; got = 0;
        while (!got && cnt < 8) begin
            @(negedge clk);
            cnt++;
            if (cnt == 1) check("readnum_a", {29'h0, rf_readnum}, {29'h0, a});
            if (cnt == 2) check("readnum_b", {29'h0, rf_readnum}, {29'h0, b});
            if (out_valid) got = 1;
            else begin
                @(posedge clk); #1;
                wb_valid = 1'b0;
            end
        end
        check("latency", cnt, 32'd3);
        if (!got) begin
            void'(sb_q.pop_back());
            @(posedge clk); #1;
            return;
        end
        for (int h = 0; h < hold; h++) begin
            check("hold_a", {16'h0, out_a}, {16'h0, ea});
            check("hold_b", {16'h0, out_b}, {16'h0, eb});
            check("hold_req_ready", {31'h0, req_ready}, 32'd0);
            @(posedge clk); #1;
            if (h == hold - 1) out_ready = 1'b1;
            @(negedge clk);
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(negedge clk);
        check("post_valid", {31'h0, out_valid}, 32'd0);
        check("post_ready", {31'h0, req_ready}, 32'd1);
        @(posedge clk); #1;
    endtask

    typedef struct {
        reg_num_t  rs_a;
        reg_num_t  rs_b;
        reg_data_t exp_a;
        reg_data_t exp_b;
        int        hold;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int accepts;
        reg_data_t exp_byp;

        vecs[0] = '{3'd3, 3'd5, 16'h1234, 16'hBEEF, 0};
        vecs[1] = '{3'd5, 3'd3, 16'hBEEF, 16'h1234, 0};
        vecs[2] = '{3'd7, 3'd7, 16'hA5A5, 16'hA5A5, 0};
        vecs[3] = '{3'd0, 3'd1, 16'hFFFF, 16'h0F0F, 5};
        vecs[4] = '{3'd4, 3'd6, 16'h4444, 16'h6666, 0};
        vecs[5] = '{3'd2, 3'd0, 16'h0001, 16'hFFFF, 2};

        reset = 1'b1; req_valid = 1'b0; req_rs_a = '0; req_rs_b = '0;
        out_ready = 1'b0; wb_valid = 1'b0; wb_rd = '0; wb_data = '0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", {31'h0, req_ready}, 32'd1);
        check("rst_out_valid", {31'h0, out_valid}, 32'd0);
        check("rst_out_a", {16'h0, out_a}, 32'd0);
        check("rst_readnum", {29'h0, rf_readnum}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        wb_write(3'd0, 16'hFFFF);
        wb_write(3'd1, 16'h0F0F);
        wb_write(3'd2, 16'h0001);
        wb_write(3'd3, 16'h1234);
        wb_write(3'd4, 16'h4444);
        wb_write(3'd5, 16'hBEEF);
        wb_write(3'd6, 16'h6666);
        wb_write(3'd7, 16'hA5A5);

        for (int i = 0; i < 6; i++)
            fetch(vecs[i].rs_a, vecs[i].rs_b, vecs[i].exp_a, vecs[i].exp_b, vecs[i].hold, 1'b0, '0);

        // Reset asserted mid-RD_B with writeback active throughout.
        req_valid = 1'b1; req_rs_a = 3'd3; req_rs_b = 3'd5;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check("rdb_readnum", {29'h0, rf_readnum}, 32'd5);
        #1;
        reset = 1'b1;
        wb_valid = 1'b1; wb_rd = 3'd6; wb_data = 16'h6666;
        #1;
        check("arst_out_a", {16'h0, out_a}, 32'd0);
        check("arst_out_b", {16'h0, out_b}, 32'd0);
        check("arst_readnum", {29'h0, rf_readnum}, 32'd0);
        check("rst_wb_write", {31'h0, rf_write}, 32'd1);
        check("rst_wb_wnum", {29'h0, rf_wnum}, 32'd6);
        check("rst_wb_wdata", {16'h0, rf_wdata}, 32'h6666);
        @(posedge clk); #1;
        reset = 1'b0; wb_valid = 1'b0;
        @(negedge clk);
        check("rel_req_ready", {31'h0, req_ready}, 32'd1);
        check("rel_out_valid", {31'h0, out_valid}, 32'd0);
        check("rel_out_a", {16'h0, out_a}, 32'd0);
        check("rel_out_b", {16'h0, out_b}, 32'd0);
        @(posedge clk); #1;

        // Writeback to R2 during RD_A of a fetch reading R2.
`ifdef OPERAND_FETCH_BYPASS_EN
        exp_byp = 16'h00FF;
`else
        exp_byp = 16'h0001;
`endif
        fetch(3'd2, 3'd0, exp_byp, 16'hFFFF, 0, 1'b1, 16'h00FF);
        fetch(3'd2, 3'd2, 16'h00FF, 16'h00FF, 0, 1'b0, '0);

        // req_valid held high for 8 cycles, writeback to R6 every cycle.
        sb_q.push_back({16'h0F0F, 16'h4444});
        sb_q.push_back({16'h0F0F, 16'h4444});
        req_valid = 1'b1; req_rs_a = 3'd1; req_rs_b = 3'd4; out_ready = 1'b1;
        accepts = 0; wr6_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            wb_valid = 1'b1; wb_rd = 3'd6; wb_data = 16'h6000 + 16'(i);
            @(negedge clk);
            if (req_valid && req_ready) accepts++;
            @(posedge clk); #1;
        end
        req_valid = 1'b0; wb_valid = 1'b0; out_ready = 1'b0; wr6_en = 1'b0;
        check("b2b_accepts", accepts, 32'd2);
        check("b2b_wb_count", wr6_cnt, 32'd8);
        fetch(3'd6, 3'd6, 16'h6007, 16'h6007, 0, 1'b0, '0);

        check("sb_empty", sb_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
